// File: rtl/boton_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a counter-based
// debounce FSM that emits a clean level and a one-cycle pulse per press.
module boton_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       boton_i,
  output logic       boton_db_o,
  output logic       pulso_o,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } state_t;

  logic             sync1;
  logic             sync2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_nxt;
  logic             pulso_nxt;

  // Only sync2 is allowed to reach the FSM; sync1 may be metastable.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= boton_i;
      sync2 <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulso_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt = CHECK_PRESS;
          cnt_nxt   = '0;
        end
      end
      CHECK_PRESS: begin
        if (!sync2) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
          pulso_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_nxt = CHECK_RELEASE;
          cnt_nxt   = '0;
        end
      end
      CHECK_RELEASE: begin
        // Returning to PRESSED here never re-arms the pulse.
        if (sync2) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    db_nxt = (state_nxt == PRESSED) || (state_nxt == CHECK_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      boton_db_o <= 1'b0;
      pulso_o    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      boton_db_o <= db_nxt;
      pulso_o    <= pulso_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_boton_debounce.sv
// Bench for boton_debounce (DEBOUNCE_CYCLES=4): expected pulse cycles are
// queued as stimulus is driven and matched against observed pulses.
module tb_boton_debounce;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic       clk;
  logic       reset_i;
  logic       boton_i;
  logic       boton_db_o;
  logic       pulso_o;
  logic [1:0] state_dbg;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_presses = 0;
  logic [7:0] conta = 8'h00;
  logic [31:0] exp_q[$];

  boton_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .boton_i    (boton_i),
    .boton_db_o (boton_db_o),
    .pulso_o    (pulso_o),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every observed pulse must match the oldest expected cycle
  always @(negedge clk) begin
    if (pulso_o === 1'b1) begin
      conta <= conta + 8'h01;
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", 32'd1, 32'd0);
      end else begin
        check("pulse_cycle", 32'(cyc), exp_q.pop_front());
      end
    end
  end

  // driver: hold a level for n cycles, checking the debounced level each cycle
  task automatic run_level(input logic v, input int n, input int flip_k,
                           input logic db_before, input logic db_after);
    for (int k = 1; k <= n; k++) begin
      boton_i = v;
      @(negedge clk);
      check("boton_db", 32'(boton_db_o), 32'((k >= flip_k) ? db_after : db_before));
    end
  endtask

  task automatic expect_press();
    exp_q.push_back(32'(cyc + LAT));
    exp_presses++;
  endtask

  initial begin
    int len;
    reset_i = 1'b1;
    boton_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_db", 32'(boton_db_o), 32'd0);
      check("rst_pulse", 32'(pulso_o), 32'd0);
    end
    check("rst_state", 32'(state_dbg), 32'd0);
    reset_i = 1'b0;
    run_level(1'b0, 4, 99, 1'b0, 1'b0);

    // clean press and release
    expect_press();
    run_level(1'b1, 20, LAT, 1'b0, 1'b1);
    run_level(1'b0, 12, LAT, 1'b1, 1'b0);

    // bounce then stable press
    for (int i = 0; i < 6; i++) begin
      boton_i = (i % 2 == 0);
      @(negedge clk);
      check("bounce_db", 32'(boton_db_o), 32'd0);
    end
    expect_press();
    run_level(1'b1, 14, LAT, 1'b0, 1'b1);
    run_level(1'b0, 12, LAT, 1'b1, 1'b0);

    // short glitches never qualify
    run_level(1'b1, 2, 99, 1'b0, 1'b0);
    run_level(1'b0, 10, 99, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, D - 1);
      run_level(1'b1, len, 99, 1'b0, 1'b0);
      run_level(1'b0, 8, 99, 1'b0, 1'b0);
    end

    // release bounce while pressed
    expect_press();
    run_level(1'b1, 10, LAT, 1'b0, 1'b1);
    run_level(1'b0, 2, 99, 1'b1, 1'b1);
    run_level(1'b1, 8, 99, 1'b1, 1'b1);
    run_level(1'b0, 12, LAT, 1'b1, 1'b0);

    // reset during CHECK_PRESS with the button still held
    run_level(1'b1, 4, 99, 1'b0, 1'b0);
    check("midpress_state", 32'(state_dbg), 32'd1);
    reset_i = 1'b1;
    run_level(1'b1, 2, 99, 1'b0, 1'b0);
    reset_i = 1'b0;
    expect_press();
    run_level(1'b1, 12, LAT, 1'b0, 1'b1);
    run_level(1'b0, 12, LAT, 1'b1, 1'b0);

    run_level(1'b0, 4, 99, 1'b0, 1'b0);
    check("pulse_missing", 32'(exp_q.size()), 32'd0);
    check("conta", 32'(conta), 32'(exp_presses));
    check("end_state", 32'(state_dbg), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/boton_debounce.md
Name: boton_debounce

Overview:
- Conditions the raw push-button line before the 8-bit `contador` stage.
- Synchronises the asynchronous button input with a 2-FF chain, then debounces it with a counter-based FSM.
- Emits a clean level and a single-cycle press pulse. `pulso_o` drives `contador.boton_i` directly, so each physical press advances `conta_o` exactly once.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a press or release. Legal range ≥ 2. Board builds override it (e.g. 1_000_000 at 100 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the internal stability counter. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- boton_i  input  1  raw, asynchronous, bouncing button level; 1 = pressed.
- boton_db_o  output  1  debounced button level, registered.
- pulso_o  output  1  one-cycle high pulse per accepted press, registered; feeds the counter.

Behaviour:
- Interface (fixed): one clock `clk`; reset `reset_i` is synchronous and active-high.
- Reset, when `reset_i`=1 at a rising edge:
  - sync1, sync2 = 0; state = IDLE; cnt = 0.
  - boton_db_o = 0; pulso_o = 0.
  - Reset has priority over every other event.
- Synchroniser: sync1 <= boton_i; sync2 <= sync1. The FSM sees only sync2. Two cycles of latency.
- States:
  - IDLE (level 0)
  - CHECK_PRESS
  - PRESSED (level 1)
  - CHECK_RELEASE
- Transitions, evaluated every edge:
  - IDLE: sync2=1 -> CHECK_PRESS, cnt=0.
  - CHECK_PRESS:
    - sync2=0 -> IDLE (bounce rejected, no output).
    - else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
    - else cnt++.
  - PRESSED: sync2=0 -> CHECK_RELEASE, cnt=0.
  - CHECK_RELEASE:
    - sync2=1 -> PRESSED (no new pulse).
    - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - else cnt++.
- Outputs, registered and updated on the same edge as the state:
  - boton_db_o=1 whenever the next state is PRESSED or CHECK_RELEASE, else 0.
  - pulso_o=1 only on the edge that moves CHECK_PRESS->PRESSED; 0 on all other edges.
- Latency: let edge 1 be the first edge at which boton_i=1 is sampled, with boton_i held stable.
  - Edge DEBOUNCE_CYCLES+3 sets boton_db_o=1 and pulso_o=1.
  - The next edge clears pulso_o.
- Release latency: same structure. boton_db_o falls on edge DEBOUNCE_CYCLES+3 after the first sample of 0.
- Pulse width: exactly 1 cycle, independent of hold time. No auto-repeat.
- Glitches: a high or low excursion of sync2 shorter than DEBOUNCE_CYCLES samples leaves the outputs unchanged.
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps. It is reloaded to 0 on entry to either CHECK state.
- Reset mid-operation:
  - Reset during CHECK_PRESS or PRESSED yields no pulse for that press.
  - If the button is still held after reset deasserts, it is treated as a new press and produces one pulse after the full latency.
- Deassertion: the first edge after reset deasserts behaves as edge 1 of normal operation.

Test Plan (DEBOUNCE_CYCLES=4, clk period 10 ns):
- Reset: reset_i=1 for 2 cycles with boton_i=0 -> boton_db_o=0, pulso_o=0 throughout and after.
- Clean press: boton_i=1 held 20 cycles from edge 1 -> boton_db_o and pulso_o rise at edge 7; pulso_o low from edge 8; exactly one pulse; downstream conta_o goes 0x00->0x01.
- Bounce: boton_i toggles 1,0,1,0 each cycle for 6 cycles, then held 1 -> no pulse during the bounce; exactly one pulse 7 edges after the final stable 1 is first sampled.
- Short glitch: boton_i=1 for 2 cycles, then 0 -> pulso_o and boton_db_o never assert.
- Release bounce: while pressed, boton_i drops for 2 cycles then returns to 1 -> boton_db_o stays 1, no second pulse. A full release then drops boton_db_o at edge 7 of the low level.
- Reset mid-press: assert reset_i during CHECK_PRESS with boton_i held 1 -> no pulse during reset; exactly one pulse at edge 7 after reset deasserts.
